// File: rtl/alu_share_sched_pkg.sv
// Shared definitions for the ALU time-share scheduler: operation codes,
// legality check and FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } sched_state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_sched_if.sv
// Bundle of the two request channels, the ALU connection and the response
// channel. The scheduler takes the slave view; requesters/ALU/consumer take master.
interface alu_share_sched_if #(
    parameter int unsigned DATA_W = 64
);
    logic              req0_valid;
    logic              req0_ready;
    logic [3:0]        req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [3:0]        req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_err;
    logic              busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_op, alu_a, alu_b,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_op, alu_a, alu_b,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
        output rsp_ready,
        input  busy
    );

endinterface

// File: rtl/alu_share_sched_rr_arb2.sv
// Combinational two-way round-robin arbiter: a lone requester always wins,
// on contention the port that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic       o_gnt_valid,
    output logic       o_gnt_idx
);

    always_comb begin
        o_gnt_valid = |i_valid;
        o_gnt_idx   = 1'b0;
        case (i_valid)
            2'b01:   o_gnt_idx = 1'b0;
            2'b10:   o_gnt_idx = 1'b1;
            2'b11:   o_gnt_idx = ~i_last_grant;
            default: o_gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_share_sched.sv
// Time-shares one ALU between the fetch/branch port (0) and the execute port (1),
// waiting ALU_LAT cycles per legal operation and returning a tagged response.
module alu_share_sched
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_sched_if.slave bus
);

    localparam logic [2:0] CNT_INIT = 3'(ALU_LAT - 1);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;

    logic [1:0]        w_req_valid;
    logic              w_gnt_valid;
    logic              w_gnt_idx;
    logic              w_xfer;
    logic              w_op_legal;
    logic [3:0]        w_op;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;

    logic [3:0]        r_alu_op;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [2:0]        r_count;
    logic              r_last_grant;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_zero;
    logic              r_rsp_err;

    assign w_req_valid = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_arb (
        .i_valid      (w_req_valid),
        .i_last_grant (r_last_grant),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_idx    (w_gnt_idx)
    );

    assign w_op       = w_gnt_idx ? bus.req1_op : bus.req0_op;
    assign w_a        = w_gnt_idx ? bus.req1_a  : bus.req0_a;
    assign w_b        = w_gnt_idx ? bus.req1_b  : bus.req0_b;
    assign w_xfer     = (r_state == IDLE) && w_gnt_valid;
    assign w_op_legal = is_legal_op(w_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = w_op_legal ? EXEC : RESP;
                end
            end
            EXEC: begin
                if (r_count == 3'd0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                // No grant in the handshake cycle; arbitration resumes from IDLE.
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_count      <= '0;
            r_last_grant <= 1'b1;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_alu_op     <= w_op;
                        r_alu_a      <= w_a;
                        r_alu_b      <= w_b;
                        r_rsp_id     <= w_gnt_idx;
                        r_last_grant <= w_gnt_idx;
                        if (w_op_legal) begin
                            r_count <= CNT_INIT;
                        end else begin
                            r_rsp_result <= '0;
                            r_rsp_zero   <= 1'b0;
                            r_rsp_err    <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (r_count == 3'd0) begin
                        r_rsp_result <= bus.alu_result;
                        r_rsp_zero   <= bus.alu_zero;
                        r_rsp_err    <= 1'b0;
                    end else begin
                        r_count <= r_count - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = w_xfer && !w_gnt_idx;
    assign bus.req1_ready = w_xfer &&  w_gnt_idx;

    assign bus.alu_op     = r_alu_op;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;

    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_share_sched.sv
// Scoreboard bench: two schedulers (ALU_LAT=1 and ALU_LAT=4) driven with directed
// requests; expected responses are queued at grant time and checked by monitors.
module tb_alu_share_sched;
    import alu_pkg::*;

    localparam int unsigned DW = 64;

    typedef struct {
        logic          id;
        logic [DW-1:0] result;
        logic          zero;
        logic          err;
        int            cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    exp_t qA[$];
    exp_t qB[$];
    logic prevA = 1'b0;
    logic prevB = 1'b0;

    alu_share_sched_if #(.DATA_W(DW)) ifA ();
    alu_share_sched_if #(.DATA_W(DW)) ifB ();

    alu_share_sched #(.DATA_W(DW), .ALU_LAT(1)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
    alu_share_sched #(.DATA_W(DW), .ALU_LAT(4)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] alu_model(input logic [3:0] op, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        case (op)
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_PASSB: return b;
            default:   return 64'hDEAD_BEEF_0BAD_F00D;
        endcase
    endfunction

    assign ifA.alu_result = alu_model(ifA.alu_op, ifA.alu_a, ifA.alu_b);
    assign ifA.alu_zero   = (ifA.alu_result == '0);
    assign ifB.alu_result = alu_model(ifB.alu_op, ifB.alu_a, ifB.alu_b);
    assign ifB.alu_zero   = (ifB.alu_result == '0);

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endfunction

    always @(negedge clk) begin
        if (ifA.rsp_valid === 1'b1) begin
            if (qA.size() == 0) begin
                chk("A_unexpected_rsp", 1, 0);
            end else begin
                chk("A_rsp_id", ifA.rsp_id, qA[0].id);
                chk("A_rsp_result", ifA.rsp_result, qA[0].result);
                chk("A_rsp_zero", ifA.rsp_zero, qA[0].zero);
                chk("A_rsp_err", ifA.rsp_err, qA[0].err);
                if (!prevA) chk("A_rsp_cycle", cyc, qA[0].cyc);
                if (ifA.rsp_ready) void'(qA.pop_front());
            end
        end
        prevA = ifA.rsp_valid;
    end

    always @(negedge clk) begin
        if (ifB.rsp_valid === 1'b1) begin
            if (qB.size() == 0) begin
                chk("B_unexpected_rsp", 1, 0);
            end else begin
                chk("B_rsp_id", ifB.rsp_id, qB[0].id);
                chk("B_rsp_result", ifB.rsp_result, qB[0].result);
                chk("B_rsp_zero", ifB.rsp_zero, qB[0].zero);
                chk("B_rsp_err", ifB.rsp_err, qB[0].err);
                if (!prevB) chk("B_rsp_cycle", cyc, qB[0].cyc);
                if (ifB.rsp_ready) void'(qB.pop_front());
            end
        end
        prevB = ifB.rsp_valid;
    end

    task automatic drive_req(input bit dut, input bit port, input logic [3:0] op,
                             input logic [DW-1:0] a, input logic [DW-1:0] b, input logic v);
        if (!dut) begin
            if (!port) begin ifA.req0_valid = v; ifA.req0_op = op; ifA.req0_a = a; ifA.req0_b = b; end
            else       begin ifA.req1_valid = v; ifA.req1_op = op; ifA.req1_a = a; ifA.req1_b = b; end
        end else begin
            if (!port) begin ifB.req0_valid = v; ifB.req0_op = op; ifB.req0_a = a; ifB.req0_b = b; end
            else       begin ifB.req1_valid = v; ifB.req1_op = op; ifB.req1_a = a; ifB.req1_b = b; end
        end
    endtask

    task automatic wait_grant(input bit dut, input bit port, output int gc);
        logic rdy;
        gc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!dut) rdy = port ? ifA.req1_ready : ifA.req0_ready;
            else      rdy = port ? ifB.req1_ready : ifB.req0_ready;
            if (rdy === 1'b1) begin
                gc = cyc;
                break;
            end
        end
        if (gc < 0) fail_now("grant_wait");
    endtask

    task automatic wait_idle(input bit dut);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!dut) done = (ifA.busy === 1'b0) && (qA.size() == 0);
            else      done = (ifB.busy === 1'b0) && (qB.size() == 0);
            if (done) break;
        end
        if (!done) fail_now("idle_wait");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int gc, t0, got, prev, hs;

        drive_req(0, 0, '0, '0, '0, 0);
        drive_req(0, 1, '0, '0, '0, 0);
        drive_req(1, 0, '0, '0, '0, 0);
        drive_req(1, 1, '0, '0, '0, 0);
        ifA.rsp_ready = 1'b1;
        ifB.rsp_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", ifA.busy, 0);
        chk("rst_rsp_valid", ifA.rsp_valid, 0);
        chk("rst_alu_op", ifA.alu_op, 0);
        chk("rst_alu_a", ifA.alu_a, 0);
        chk("rst_alu_b", ifA.alu_b, 0);
        chk("rst_rsp_fields", {ifA.rsp_id, ifA.rsp_zero, ifA.rsp_err}, 0);
        chk("rst_rsp_result", ifA.rsp_result, 0);
        chk("rst_ready", {ifA.req0_ready, ifA.req1_ready}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // single ADD on port 0
        @(posedge clk); #1;
        t0 = cyc;
        drive_req(0, 0, ALU_ADD, 64'd5, 64'd7, 1);
        wait_grant(0, 0, gc);
        chk("t1_ready_cycle0", gc, t0);
        qA.push_back('{1'b0, 64'd12, 1'b0, 1'b0, gc + 2});
        @(posedge clk); #1 drive_req(0, 0, '0, '0, '0, 0);
        wait_idle(0);

        // contention from reset, SUB 9-9 on both ports
        #2 rst_n = 1'b0;
        drive_req(0, 0, ALU_SUB, 64'd9, 64'd9, 1);
        drive_req(0, 1, ALU_SUB, 64'd9, 64'd9, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            got = -1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (ifA.req0_ready === 1'b1 || ifA.req1_ready === 1'b1) begin
                    chk("t2_one_ready", ifA.req0_ready & ifA.req1_ready, 0);
                    got = (ifA.req1_ready === 1'b1) ? 1 : 0;
                    break;
                end
            end
            if (got < 0) begin
                fail_now("t2_grant_wait");
                break;
            end
            chk("t2_grant_port", got, k % 2);
            if (k > 0) chk("t2_spacing", cyc - prev, 3);
            prev = cyc;
            qA.push_back('{(got == 1), 64'd0, 1'b1, 1'b0, cyc + 2});
        end
        @(posedge clk); #1;
        drive_req(0, 0, '0, '0, '0, 0);
        drive_req(0, 1, '0, '0, '0, 0);
        wait_idle(0);

        // illegal op on port 1
        @(posedge clk); #1 drive_req(0, 1, 4'b1111, 64'd3, 64'd4, 1);
        wait_grant(0, 1, gc);
        qA.push_back('{1'b1, 64'd0, 1'b0, 1'b1, gc + 1});
        @(posedge clk); #1 drive_req(0, 1, '0, '0, '0, 0);
        wait_idle(0);

        // back-pressure with port 0 pending
        @(posedge clk); #1;
        ifA.rsp_ready = 1'b0;
        drive_req(0, 1, ALU_ADD, 64'd1, 64'd2, 1);
        wait_grant(0, 1, gc);
        qA.push_back('{1'b1, 64'd3, 1'b0, 1'b0, gc + 2});
        @(posedge clk); #1;
        drive_req(0, 1, '0, '0, '0, 0);
        drive_req(0, 0, ALU_AND, 64'hFF, 64'h0F, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifA.rsp_valid === 1'b1) break;
        end
        for (int i = 0; i < 5; i++) begin
            chk("t4_req0_ready_stall", ifA.req0_ready, 0);
            chk("t4_rsp_valid_stall", ifA.rsp_valid, 1);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1 ifA.rsp_ready = 1'b1;
        @(negedge clk);
        hs = cyc;
        chk("t4_no_grant_in_hs", ifA.req0_ready, 0);
        @(negedge clk);
        chk("t4_grant_after_hs", ifA.req0_ready, 1);
        chk("t4_grant_cycle", cyc, hs + 1);
        qA.push_back('{1'b0, 64'h0F, 1'b0, 1'b0, cyc + 2});
        @(posedge clk); #1 drive_req(0, 0, '0, '0, '0, 0);
        wait_idle(0);

        // ALU_LAT=4 instance: OR, ALU inputs held through EXEC
        @(posedge clk); #1 drive_req(1, 0, ALU_OR, 64'hF0, 64'h0F, 1);
        wait_grant(1, 0, gc);
        qB.push_back('{1'b0, 64'hFF, 1'b0, 1'b0, gc + 5});
        @(posedge clk); #1 drive_req(1, 0, '0, '0, '0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_alu_op", ifB.alu_op, ALU_OR);
            chk("t5_alu_a", ifB.alu_a, 64'hF0);
            chk("t5_alu_b", ifB.alu_b, 64'h0F);
            chk("t5_no_rsp_yet", ifB.rsp_valid, 0);
        end
        wait_idle(1);

        // async reset while in EXEC
        @(posedge clk); #1 drive_req(0, 0, ALU_ADD, 64'd1, 64'd1, 1);
        wait_grant(0, 0, gc);
        @(posedge clk); #1 drive_req(0, 0, '0, '0, '0, 0);
        chk("t6_in_exec", ifA.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy_cleared", ifA.busy, 0);
        chk("t6_alu_a_cleared", ifA.alu_a, 0);
        chk("t6_alu_op_cleared", ifA.alu_op, 0);
        chk("t6_rsp_valid_low", ifA.rsp_valid, 0);
        drive_req(0, 0, ALU_ADD, 64'd2, 64'd3, 1);
        drive_req(0, 1, ALU_ADD, 64'd2, 64'd3, 1);
        repeat (2) @(negedge clk);
        chk("t6_no_rsp_in_reset", ifA.rsp_valid, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        t0 = cyc;
        wait_grant(0, 0, gc);
        chk("t6_port0_first", gc, t0);
        qA.push_back('{1'b0, 64'd5, 1'b0, 1'b0, gc + 2});
        @(posedge clk); #1;
        drive_req(0, 0, '0, '0, '0, 0);
        drive_req(0, 1, '0, '0, '0, 0);
        wait_idle(0);

        repeat (3) @(negedge clk);
        chk("A_queue_drained", qA.size(), 0);
        chk("B_queue_drained", qB.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
